// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared width helpers and defaults for the signed fixed-point divider
//   prod_w  : width of the dividend x reciprocal product
//   rnd_pos : bit position of the round-half-up constant
//   sat_max : most positive signed pattern for a given word length
//   sat_min : most negative signed pattern for a given word length
package fp_div_pkg;

    localparam int DEF_WI      = 10;
    localparam int DEF_WF      = 10;
    // Shared with the fp_sRec instantiation so both pipelines stay aligned.
    localparam int DEF_REC_LAT = 4;

    function automatic int prod_w(input int wl, input int wio, input int wfo);
        return wl + wio + wfo;
    endfunction

    function automatic int rnd_pos(input int wfo);
        return wfo - 1;
    endfunction

    function automatic logic [127:0] sat_max(input int wl);
        return (128'd1 << (wl - 1)) - 128'd1;
    endfunction

    function automatic logic [127:0] sat_min(input int wl);
        return 128'd1 << (wl - 1);
    endfunction

endpackage

// File: rtl/fp_delay_line.sv
// fp_delay_line: CE-gated, asynchronously cleared shift register
//   CLK, nRST : clock, async active-low clear
//   CE        : advance enable
//   d         : word entering the line
//   q         : word delayed by DEPTH enabled cycles
module fp_delay_line #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         CE,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr_q [DEPTH];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else if (CE) begin
            sr_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/fp_sdiv_post.sv
// fp_sdiv_post: dividend x reciprocal post-multiply with round, saturate and div-by-zero
//   CLK, nRST, CE : clock, async active-low reset, clock enable
//   in_valid      : dividend/divisor pair presented this cycle
//   din_a         : dividend, signed WI.WF
//   div0_in       : divisor is zero
//   rec           : reciprocal from fp_sRec, signed WIO.WFO, REC_LAT cycles later
//   out_valid     : dout holds a new quotient
//   dout          : quotient, signed WI.WF, saturated
//   ovf           : saturation or divide-by-zero for this dout
module fp_sdiv_post
    import fp_div_pkg::*;
#(
    parameter int WI      = DEF_WI,
    parameter int WF      = DEF_WF,
    parameter int WL      = WI + WF,
    parameter int WIO     = WF + 2,
    parameter int WFO     = WI + WL,
    parameter int REC_LAT = DEF_REC_LAT
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               CE,
    input  logic               in_valid,
    input  logic [WL-1:0]      din_a,
    input  logic               div0_in,
    input  logic [WIO+WFO-1:0] rec,
    output logic               out_valid,
    output logic [WL-1:0]      dout,
    output logic               ovf
);

    localparam int RW = WIO + WFO;
    localparam int PW = prod_w(WL, WIO, WFO);
    localparam logic [PW-1:0] RND     = PW'(1) << rnd_pos(WFO);
    localparam logic [WL-1:0] SAT_MAX = WL'(sat_max(WL));
    localparam logic [WL-1:0] SAT_MIN = WL'(sat_min(WL));

    logic          v_dl, z_dl;
    logic [WL-1:0] a_dl;

    fp_delay_line #(.DEPTH(REC_LAT), .W(WL + 2)) u_align (
        .CLK  (CLK),
        .nRST (nRST),
        .CE   (CE),
        .d    ({in_valid, div0_in, din_a}),
        .q    ({v_dl, z_dl, a_dl})
    );

    // Both operands are sign-extended to the product width, so the low PW
    // bits of the unsigned product are the exact two's complement result.
    logic [PW-1:0] p_d, p_q;
    logic          v1_q, z1_q, s1_q, nz1_q;

    assign p_d = {{(PW-WL){a_dl[WL-1]}}, a_dl} * {{(PW-RW){rec[RW-1]}}, rec};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            p_q   <= '0;
            v1_q  <= 1'b0;
            z1_q  <= 1'b0;
            s1_q  <= 1'b0;
            nz1_q <= 1'b0;
        end else if (CE) begin
            p_q   <= p_d;
            v1_q  <= v_dl;
            z1_q  <= z_dl;
            s1_q  <= a_dl[WL-1];
            nz1_q <= |a_dl;
        end
    end

    // |p| <= 2^(PW-2), so adding the rounding constant cannot wrap.
    logic [PW-1:0] rnd;
    logic [WIO:0]  hi;
    logic          fits, ovf_d;
    logic [WL-1:0] dout_d;
    logic          unused_rnd;

    always_comb begin
        rnd    = p_q + RND;
        hi     = rnd[PW-1:WFO+WL-1];
        fits   = (&hi) | ~(|hi);
        dout_d = z1_q ? (s1_q ? SAT_MIN : (nz1_q ? SAT_MAX : '0))
               : fits ? rnd[WFO+WL-1:WFO]
               : (rnd[PW-1] ? SAT_MIN : SAT_MAX);
        ovf_d  = z1_q | ~fits;
    end

    assign unused_rnd = ^rnd[WFO-1:0];

    logic          ov_q, ovf_q;
    logic [WL-1:0] dout_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ov_q   <= 1'b0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
        end else if (CE) begin
            ov_q <= v1_q;
            if (v1_q) begin
                dout_q <= dout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = ov_q;
    assign dout      = dout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fp_sdiv_post.sv
// tb_fp_sdiv_post: directed checks of fp_sdiv_post with a modelled upstream reciprocal delay
module tb_fp_sdiv_post;

    localparam int WL  = 20;
    localparam int RW  = 42;
    localparam int LAT = 4;

    localparam logic [RW-1:0] R_Q  = 42'h0010000000;
    localparam logic [RW-1:0] R_H  = 42'h0020000000;
    localparam logic [RW-1:0] R_16 = 42'h0400000000;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          CE = 1'b1;
    logic          in_valid = 1'b0;
    logic [WL-1:0] din_a = '0;
    logic          div0_in = 1'b0;
    logic [RW-1:0] rec;
    logic          out_valid;
    logic [WL-1:0] dout;
    logic          ovf;

    fp_sdiv_post dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .CE        (CE),
        .in_valid  (in_valid),
        .din_a     (din_a),
        .div0_in   (div0_in),
        .rec       (rec),
        .out_valid (out_valid),
        .dout      (dout),
        .ovf       (ovf)
    );

    always #5 CLK = ~CLK;

    // Stand-in for fp_sRec: the reciprocal appears LAT enabled cycles later.
    logic [RW-1:0] r_in = '0;
    logic [RW-1:0] rec_pipe [LAT];
    assign rec = rec_pipe[LAT-1];

    initial for (int i = 0; i < LAT; i++) rec_pipe[i] = '0;

    always @(posedge CLK) if (CE) begin
        rec_pipe[0] <= r_in;
        for (int i = 1; i < LAT; i++) rec_pipe[i] <= rec_pipe[i-1];
    end

    int   ecyc = 0;
    logic ce_last = 1'b0;

    always @(posedge CLK) begin
        ce_last <= CE;
        if (CE) ecyc <= ecyc + 1;
    end

    typedef struct {
        logic [WL-1:0] d;
        logic          o;
        int            c;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (nRST && ce_last && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("dout", 64'(dout), 64'(e.d));
                check("ovf", 64'(ovf), 64'(e.o));
                check("latency", 64'(ecyc - e.c), 64'd6);
            end
        end
    end

    task automatic issue(input logic [WL-1:0] a, input logic z, input logic [RW-1:0] r,
                         input logic [WL-1:0] ed, input logic eo);
        exp_t e;
        in_valid = 1'b1;
        din_a    = a;
        div0_in  = z;
        r_in     = r;
        e.d = ed;
        e.o = eo;
        e.c = ecyc;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        div0_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drain;
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            idle(1);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        idle(2);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        nRST = 1'b1;
        idle(1);

        issue(20'h00800, 1'b0, R_Q, 20'h00200, 1'b0);
        drain();
        issue(20'hFFA00, 1'b0, R_H, 20'hFFD00, 1'b0);
        issue(20'h00001, 1'b0, R_H, 20'h00001, 1'b0);
        issue(20'h00001, 1'b0, R_Q, 20'h00000, 1'b0);
        issue(20'hFFFFF, 1'b0, R_H, 20'h00000, 1'b0);
        issue(20'h40000, 1'b0, R_16, 20'h7FFFF, 1'b1);
        issue(20'h80000, 1'b0, R_16, 20'h80000, 1'b1);
        issue(20'hFF000, 1'b1, R_H, 20'h80000, 1'b1);
        issue(20'h00000, 1'b1, R_H, 20'h00000, 1'b1);
        issue(20'h00400, 1'b1, R_Q, 20'h7FFFF, 1'b1);
        drain();
        check("hold_dout", 64'(dout), 64'h7FFFF);
        idle(2);
        check("hold_dout_idle", 64'(dout), 64'h7FFFF);

        for (int i = 1; i <= 4; i++) issue(20'(i * 'h100), 1'b0, R_H, 20'(i * 'h80), 1'b0);
        CE = 1'b0;
        idle(3);
        CE = 1'b1;
        for (int i = 5; i <= 8; i++) issue(20'(i * 'h100), 1'b0, R_H, 20'(i * 'h80), 1'b0);
        drain();

        issue(20'h00800, 1'b0, R_Q, 20'h00200, 1'b0);
        issue(20'h40000, 1'b0, R_16, 20'h7FFFF, 1'b1);
        issue(20'hFFA00, 1'b0, R_H, 20'hFFD00, 1'b0);
        #2;
        nRST = 1'b0;
        exp_q.delete();
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_dout", 64'(dout), 64'd0);
        check("async_ovf", 64'(ovf), 64'd0);
        idle(2);
        nRST = 1'b1;
        idle(10);
        check("post_rst_dout", 64'(dout), 64'd0);
        issue(20'hFFA00, 1'b0, R_H, 20'hFFD00, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
